// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// the default imem geometry.
package fetch_pkg;

    localparam int IMEM_ADDR_W = 12;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, hides the 1-cycle synchronous imem latency, parks the
// current instruction in a hold register on consumer stalls and flushes one bubble on redirects.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = IMEM_ADDR_W,
    parameter int              DATA_W   = INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [DATA_W-1:0] q_imem,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc_plus1,
    output logic [31:0]       retired_count
);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;
    logic [DATA_W-1:0] hold_reg;
    logic [31:0]       retired_reg;

    logic              accept;
    logic [ADDR_W-1:0] pc_plus1;

    assign pc_plus1 = pc_reg + ADDR_W'(1);

    // A redirect implies the consumer took the instruction it was shown, even under stall.
    assign accept = instr_valid && (!stall || redirect_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= FILL;
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= RESET_PC;
            hold_reg        <= '0;
            retired_reg     <= '0;
        end else begin
            if (accept) begin
                retired_reg <= retired_reg + 32'd1;
            end

            if (redirect_valid) begin
                pc_reg    <= redirect_target;
                state_reg <= FLUSH;
            end else begin
                case (state_reg)
                    FILL, FLUSH: begin
                        pc_reg          <= pc_plus1;
                        inflight_pc_reg <= pc_reg;
                        state_reg       <= RUN;
                    end
                    RUN: begin
                        if (stall) begin
                            hold_reg  <= q_imem;
                            state_reg <= HOLD;
                        end else begin
                            pc_reg          <= pc_plus1;
                            inflight_pc_reg <= pc_reg;
                        end
                    end
                    HOLD: begin
                        // imem keeps reading pc_reg, so on release its data is already current.
                        if (!stall) begin
                            pc_reg          <= pc_plus1;
                            inflight_pc_reg <= pc_reg;
                            state_reg       <= RUN;
                        end
                    end
                    default: state_reg <= FILL;
                endcase
            end
        end
    end

    always_comb begin
        instr_valid = 1'b0;
        instr_out   = '0;
        case (state_reg)
            RUN: begin
                instr_valid = 1'b1;
                instr_out   = q_imem;
            end
            HOLD: begin
                instr_valid = 1'b1;
                instr_out   = hold_reg;
            end
            default: begin
                instr_valid = 1'b0;
                instr_out   = '0;
            end
        endcase
    end

    assign address_imem   = pc_reg;
    assign instr_pc       = inflight_pc_reg;
    assign instr_pc_plus1 = inflight_pc_reg + ADDR_W'(1);
    assign retired_count  = retired_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural imem where mem[i] = i + 0x100.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] address_imem;
    logic [DATA_W-1:0] q_imem;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] instr_pc_plus1;
    logic [31:0]       retired_count;

    int vectors     = 0;
    int miscompares = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0)) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .address_imem    (address_imem),
        .q_imem          (q_imem),
        .instr_valid     (instr_valid),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_pc_plus1  (instr_pc_plus1),
        .retired_count   (retired_count)
    );

    always #5 clock = ~clock;

    // Synchronous imem: registered read of the address presented at the edge.
    always @(posedge clock) begin
        q_imem <= {{(DATA_W-ADDR_W){1'b0}}, address_imem} + 32'h100;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Checks one presented instruction and the retired count.
    task automatic expect_instr(input string tag, input logic [31:0] data, input logic [ADDR_W-1:0] pc,
                                input logic [31:0] retired);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".instr"}, instr_out, data);
        check({tag, ".pc"}, 32'(instr_pc), 32'(pc));
        check({tag, ".retired"}, retired_count, retired);
        $display("%s: valid=%0b instr=%h pc=%h pc+1=%h retired=%0d", tag, instr_valid, instr_out,
                 instr_pc, instr_pc_plus1, retired_count);
    endtask

    task automatic expect_bubble(input string tag, input logic [31:0] retired);
        check({tag, ".valid"}, 32'(instr_valid), 32'd0);
        check({tag, ".retired"}, retired_count, retired);
        $display("%s: bubble addr=%h retired=%0d", tag, address_imem, retired_count);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

        // 1: reset and fill
        tick(); tick(); tick();
        expect_bubble("reset", 32'd0);
        check("reset.addr", 32'(address_imem), 32'h0);
        check("reset.pc", 32'(instr_pc), 32'h0);
        check("reset.instr", instr_out, 32'h0);
        reset = 1'b0;
        tick(); expect_instr("fill0", 32'h100, 12'h000, 32'd0);
        tick(); expect_instr("run1", 32'h101, 12'h001, 32'd1);
        tick(); expect_instr("run2", 32'h102, 12'h002, 32'd2);
        tick(); expect_instr("run3", 32'h103, 12'h003, 32'd3);
        tick(); expect_instr("run4", 32'h104, 12'h004, 32'd4);
        tick(); expect_instr("run5", 32'h105, 12'h005, 32'd5);

        // 2: stall two cycles on pc5
        stall = 1'b1;
        tick(); expect_instr("stall_a", 32'h105, 12'h005, 32'd5);
        tick(); expect_instr("stall_b", 32'h105, 12'h005, 32'd5);
        stall = 1'b0;
        tick(); expect_instr("release", 32'h106, 12'h006, 32'd6);

        // 3: redirect to 0x040
        redirect_valid = 1'b1; redirect_target = 12'h040;
        tick(); expect_bubble("redir", 32'd7);
        check("redir.addr", 32'(address_imem), 32'h040);
        redirect_valid = 1'b0;
        tick(); expect_instr("tgt0", 32'h140, 12'h040, 32'd7);
        tick(); expect_instr("tgt1", 32'h141, 12'h041, 32'd8);

        // 4: redirect with stall while holding
        stall = 1'b1;
        tick(); expect_instr("hold", 32'h141, 12'h041, 32'd8);
        redirect_valid = 1'b1; redirect_target = 12'h010;
        tick(); expect_bubble("hold_redir", 32'd9);
        redirect_valid = 1'b0; stall = 1'b0;
        tick(); expect_instr("hr_tgt0", 32'h110, 12'h010, 32'd9);
        tick(); expect_instr("hr_tgt1", 32'h111, 12'h011, 32'd10);

        // 5: PC wrap
        redirect_valid = 1'b1; redirect_target = 12'hFFE;
        tick(); expect_bubble("wrap_redir", 32'd11);
        redirect_valid = 1'b0;
        tick(); expect_instr("wrap_ffe", 32'h10FE, 12'hFFE, 32'd11);
        check("wrap_ffe.plus1", 32'(instr_pc_plus1), 32'hFFF);
        tick(); expect_instr("wrap_fff", 32'h10FF, 12'hFFF, 32'd12);
        check("wrap_fff.plus1", 32'(instr_pc_plus1), 32'h000);
        check("wrap_fff.addr", 32'(address_imem), 32'h000);
        tick(); expect_instr("wrap_000", 32'h100, 12'h000, 32'd13);
        check("wrap_000.plus1", 32'(instr_pc_plus1), 32'h001);

        // 6: reset in HOLD with stall and redirect asserted
        stall = 1'b1;
        tick(); expect_instr("pre_rst_hold", 32'h100, 12'h000, 32'd13);
        reset = 1'b1; redirect_valid = 1'b1; redirect_target = 12'h055;
        tick(); expect_bubble("rst_hold", 32'd0);
        check("rst_hold.addr", 32'(address_imem), 32'h0);
        check("rst_hold.pc", 32'(instr_pc), 32'h0);
        tick(); expect_bubble("rst_hold2", 32'd0);
        reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        tick(); expect_instr("restart0", 32'h100, 12'h000, 32'd0);
        tick(); expect_instr("restart1", 32'h101, 12'h001, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
